collision_scorer: RTL and testbench
===================================

# collision_scorer

Frame-rate judge stage that sits directly downstream of the game controller. It consumes the bird height and the three-slot pipe array each frame, detects collisions and pipe passes, and drives the 2-bit `gameState` bus used by the renderer. It also keeps a 3-digit BCD score for the seven-segment display.

## Interface
Parameters:
- `BIRD_X`, 10'd100: fixed bird left edge, in pixels.
- `BIRD_SIZE`, 10'd16: bird square side.
- `PIPE_W`, 10'd40: pipe width.
- `GAP_H`, 10'd80: vertical gap height.
- `SCREEN_H`, 10'd480: playfield height.
- `DEATH_FRAMES`, 60: frames held in DYING.

Ports:
- `clk`  in  1: frame clock, 60 Hz; one rising edge per frame.
- `rst_n`  in  1: reset. The clock is single; reset is asynchronous and active-low.
- `buttons`  in  2: `[1]` is jump/start, `[0]` is restart.
- `bird`  in  10 signed: bird top y.
- `pipes`  in  20 ×3: `{x[19:10], gap_top[9:0]}`. A value of 0 marks an empty slot.
- `gameState`  out  2: 0 IDLE, 1 PLAYING, 2 DYING, 3 OVER.
- `score`  out  12: 3-digit BCD, `[11:8]` hundreds.
- `hiscore`  out  12: 3-digit BCD best score.
- `collide`  out  1: registered collision flag.

## Operation
- **Button edges.** Each button goes through a 2-stage shift register. An edge is the pattern `2'b01`.
- **Collision term, per non-empty slot i.**
  - h_overlap = `x < BIRD_X+BIRD_SIZE` and `x+PIPE_W > BIRD_X`.
  - v_hit = `bird < gap_top` or `bird+BIRD_SIZE > gap_top+GAP_H`.
  - hit_i = h_overlap & v_hit.
- **Bounds term.** bounds = `bird < 0` or `bird+BIRD_SIZE > SCREEN_H`.
- **Arithmetic width.** All comparisons are done in 12-bit signed after sign/zero extension. There is no wrap.
- `collide` is registered from (OR of hit_i) | bounds every frame, regardless of state.
- **Pass detection.**
  - at_line = any non-empty slot with `x == BIRD_X - PIPE_W`.
  - pass = at_line & !at_line_q.
  - A pipe held at the same x for two frames (shift frame) counts once.
- **FSM.**
  - IDLE → PLAYING on a jump edge. Score clears to 0 on this transition.
  - PLAYING → DYING when `collide` = 1.
  - DYING → OVER after `DEATH_FRAMES` frames. The counter loads at DYING entry.
  - OVER → IDLE on a restart edge. The jump edge is ignored in OVER.
- **Score.** Increments by 1 BCD only in PLAYING on pass with `collide` = 0. It saturates at 12'h999.
- **Hiscore.** Updated on the DYING→OVER transition when `score > hiscore`.

## Timing
- Reset values: `gameState` = IDLE, `score` = 0, `hiscore` = 0, `collide` = 0, edge shift registers = 0, death counter = 0.
- `collide` lags its inputs by 1 frame.
- `gameState` leaves PLAYING 1 frame after `collide` rises, so the total delay from geometry to state change is 2 frames.
- A button edge changes `gameState` 2 frames after the raw button rises, because of the shift-register delay.
- `score` updates 1 frame after at_line first goes high.
- Pass and collision in the same frame: no increment, because collision wins.
- Jump and restart edges in the same frame:
  - In OVER, restart → IDLE.
  - In IDLE, jump → PLAYING.
- Asynchronous `rst_n` mid-game clears everything immediately, including `hiscore`.
- DYING lasts exactly `DEATH_FRAMES` frames. A value of 1 gives a 1-frame DYING.

## Configuration
- `FLAPPY_HISCORE_EN` defined: the hiscore register and comparator are built.
- Not defined: `hiscore` is tied to 12'h000 and no register is synthesized.
- All other behaviour is identical either way.

## Structure
- `flappy_pkg` holds:
  - the `game_state_t` enum (IDLE, PLAYING, DYING, OVER);
  - the pipe field slice constants `PIPE_X_HI/LO` and `GAP_LO/HI`;
  - `NUM_PIPES` = 3;
  - the shared screen constants.
- One sub-module, `bcd_counter3`: a 3-digit BCD incrementer with synchronous clear, saturation at 999, and a magnitude-compare helper output.

## Test plan
- IDLE, jump pulse 1 frame, `pipes` all 0, `bird` = 200 → `gameState` = 1 two frames later; `score` = 0.
- PLAYING, pipe `{10'd60, 10'd150}`, `bird` = 180 → no collide. Pipe x steps 61→60, with a 2-frame hold at 60 → `score` = 12'h001 exactly once.
- PLAYING, pipe x = 110, gap_top = 150, `bird` = 100 → `collide` = 1 next frame. Then DYING, then OVER after 60 frames; `hiscore` = prior score when greater.
- PLAYING, `bird` = −5 → collide → DYING. Same for `bird` = 470.
- `score` preset to 999 via 999 passes (or force) → a further pass keeps 12'h999.
- OVER, jump and restart pressed together → IDLE. Assert `rst_n` low mid-DYING → all outputs reset asynchronously.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared types and constants for the flappy judge stage: game states, pipe
// word field positions, default geometry and 12-bit signed coordinate helpers.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    DYING   = 2'd2,
    OVER    = 2'd3
  } game_state_t;

  localparam int NUM_PIPES = 3;

  // Pipe word layout: {x[19:10], gap_top[9:0]}.
  localparam int PIPE_X_HI = 19;
  localparam int PIPE_X_LO = 10;
  localparam int GAP_HI    = 9;
  localparam int GAP_LO    = 0;

  localparam logic [9:0] DEF_BIRD_X    = 10'd100;
  localparam logic [9:0] DEF_BIRD_SIZE = 10'd16;
  localparam logic [9:0] DEF_PIPE_W    = 10'd40;
  localparam logic [9:0] DEF_GAP_H     = 10'd80;
  localparam logic [9:0] DEF_SCREEN_H  = 10'd480;

  localparam logic [11:0] SCORE_MAX = 12'h999;

  // Geometry is compared in 12-bit signed so sums never wrap.
  typedef logic signed [11:0] coord_t;

  function automatic coord_t zext(input logic [9:0] v);
    return coord_t'({2'b00, v});
  endfunction

  function automatic coord_t sext(input logic signed [9:0] v);
    return coord_t'({{2{v[9]}}, v});
  endfunction

endpackage

// File: rtl/collision_scorer_if.sv
// Frame bus between the game controller / renderer and the collision scorer.
interface collision_scorer_if;
  import flappy_pkg::*;

  logic [1:0]                  buttons;
  logic signed [9:0]           bird;
  logic [NUM_PIPES-1:0][19:0]  pipes;
  game_state_t                 gameState;
  logic [11:0]                 score;
  logic [11:0]                 hiscore;
  logic                        collide;

  modport master (
    output buttons, bird, pipes,
    input  gameState, score, hiscore, collide
  );

  modport slave (
    input  buttons, bird, pipes,
    output gameState, score, hiscore, collide
  );

endinterface

// File: rtl/bcd_counter3.sv
// Three-digit packed-BCD counter with synchronous clear, saturation at 999 and
// a greater-than comparison against an external BCD value.
module bcd_counter3
  import flappy_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        inc_i,
  input  logic [11:0] cmp_i,
  output logic [11:0] count_o,
  output logic        gt_o
);

  logic [11:0] count_q, count_d;

  // NOTE: count_d is defaulted before any branch so every path assigns it and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != SCORE_MAX)) begin
      if (count_q[3:0] == 4'd9) begin
        count_d[3:0] = 4'd0;
        if (count_q[7:4] == 4'd9) begin
          count_d[7:4]  = 4'd0;
          count_d[11:8] = count_q[11:8] + 4'd1;
        end else begin
          count_d[7:4] = count_q[7:4] + 4'd1;
        end
      end else begin
        count_d[3:0] = count_q[3:0] + 4'd1;
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  // Packed BCD orders the same way as binary, so a plain compare is exact.
  assign gt_o    = count_q > cmp_i;
  assign count_o = count_q;

endmodule

// File: rtl/collision_scorer.sv
// Frame-rate judge: collision and pass detection, game FSM and BCD score.
// Build option FLAPPY_HISCORE_EN adds the best-score register; otherwise hiscore reads 0.
module collision_scorer
  import flappy_pkg::*;
#(
  parameter logic [9:0] BIRD_X       = DEF_BIRD_X,
  parameter logic [9:0] BIRD_SIZE    = DEF_BIRD_SIZE,
  parameter logic [9:0] PIPE_W       = DEF_PIPE_W,
  parameter logic [9:0] GAP_H        = DEF_GAP_H,
  parameter logic [9:0] SCREEN_H     = DEF_SCREEN_H,
  parameter int         DEATH_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  collision_scorer_if.slave  bus
);

  localparam coord_t BX = zext(BIRD_X);
  localparam coord_t BS = zext(BIRD_SIZE);
  localparam coord_t PW = zext(PIPE_W);
  localparam coord_t GH = zext(GAP_H);
  localparam coord_t SH = zext(SCREEN_H);

  localparam int                CNT_W      = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [CNT_W-1:0]  DEATH_LOAD = CNT_W'(DEATH_FRAMES - 1);

  // ---------------------------------------------------------------- buttons
  logic [1:0] jump_sr_q, restart_sr_q;
  logic       jump_edge, restart_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jump_sr_q    <= '0;
      restart_sr_q <= '0;
    end else begin
      jump_sr_q    <= {jump_sr_q[0], bus.buttons[1]};
      restart_sr_q <= {restart_sr_q[0], bus.buttons[0]};
    end
  end

  assign jump_edge    = (jump_sr_q == 2'b01);
  assign restart_edge = (restart_sr_q == 2'b01);

  // ---------------------------------------------------------------- geometry
  coord_t bird_w;
  coord_t pipe_x, gap_top;
  logic   occupied, h_overlap, v_hit;
  logic   hit_any, at_line, bounds, collide_d;

  assign bird_w = sext(bus.bird);

  always_comb begin
    pipe_x    = '0;
    gap_top   = '0;
    occupied  = 1'b0;
    h_overlap = 1'b0;
    v_hit     = 1'b0;
    hit_any   = 1'b0;
    at_line   = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      pipe_x    = zext(bus.pipes[i][PIPE_X_HI:PIPE_X_LO]);
      gap_top   = zext(bus.pipes[i][GAP_HI:GAP_LO]);
      occupied  = |bus.pipes[i];
      h_overlap = (pipe_x < BX + BS) && (pipe_x + PW > BX);
      v_hit     = (bird_w < gap_top) || (bird_w + BS > gap_top + GH);
      if (occupied && h_overlap && v_hit) hit_any = 1'b1;
      if (occupied && (pipe_x == BX - PW)) at_line = 1'b1;
    end
  end

  assign bounds    = (bird_w < 12'sd0) || (bird_w + BS > SH);
  assign collide_d = hit_any | bounds;

  // ---------------------------------------------------------------- FSM
  game_state_t       state_q;
  logic [CNT_W-1:0]  death_cnt_q;
  logic              at_line_q, collide_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      death_cnt_q <= '0;
      at_line_q   <= 1'b0;
      collide_q   <= 1'b0;
    end else begin
      at_line_q <= at_line;
      collide_q <= collide_d;
      case (state_q)
        IDLE:    if (jump_edge) state_q <= PLAYING;
        PLAYING: if (collide_q) begin
                   state_q     <= DYING;
                   death_cnt_q <= DEATH_LOAD;
                 end
        DYING:   if (death_cnt_q == '0) state_q <= OVER;
                 else                   death_cnt_q <= death_cnt_q - CNT_W'(1);
        OVER:    if (restart_edge) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- score
  logic        pass, score_clr, score_inc, score_gt;
  logic [11:0] score_w, hiscore_w;

  // A pipe held on the line for several frames scores once; any collision blocks the point.
  assign pass      = at_line & ~at_line_q;
  assign score_clr = (state_q == IDLE) && jump_edge;
  assign score_inc = (state_q == PLAYING) && pass && !collide_d && !collide_q;

  bcd_counter3 u_score (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (score_clr),
    .inc_i   (score_inc),
    .cmp_i   (hiscore_w),
    .count_o (score_w),
    .gt_o    (score_gt)
  );

`ifdef FLAPPY_HISCORE_EN
  logic [11:0] hiscore_q;
  logic        over_entry;

  assign over_entry = (state_q == DYING) && (death_cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       hiscore_q <= '0;
    else if (over_entry && score_gt)  hiscore_q <= score_w;
  end

  assign hiscore_w = hiscore_q;
`else
  logic unused_score_gt;
  assign unused_score_gt = score_gt;
  assign hiscore_w       = '0;
`endif

  assign bus.gameState = state_q;
  assign bus.score     = score_w;
  assign bus.hiscore   = hiscore_w;
  assign bus.collide   = collide_q;

endmodule

// File: tb/tb_collision_scorer.sv
// Scoreboard bench for collision_scorer: directed frames push expected outputs
// tagged with a frame number; a negedge monitor pops and compares them.
module tb_collision_scorer;
  import flappy_pkg::*;

`ifdef FLAPPY_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   frame_cnt;
  int   checks;
  int   errors;

  collision_scorer_if bus_if ();

  collision_scorer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial frame_cnt = 0;
  always @(posedge clk) frame_cnt <= frame_cnt + 1;

  typedef struct {
    string tag;
    int    frame;
    int    st;
    int    sc;
    int    hi;
    int    col;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int hi(input int v);
    return HI_EN ? v : 0;
  endfunction

  function automatic logic [19:0] pipe(input int x, input int g);
    return {10'(x), 10'(g)};
  endfunction

  task automatic set_in(input logic [1:0] b, input int y, input logic [19:0] p0);
    bus_if.buttons  = b;
    bus_if.bird     = 10'(y);
    bus_if.pipes[0] = p0;
    bus_if.pipes[1] = '0;
    bus_if.pipes[2] = '0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input string tag, input int d, input int st, input int sc,
                           input int hv, input int col);
    exp_t e;
    e.tag = tag; e.frame = frame_cnt + d; e.st = st; e.sc = sc; e.hi = hv; e.col = col;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation due at or before this frame.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].frame <= frame_cnt) begin
      mon_e = sb.pop_front();
      check({mon_e.tag, ".state"},   int'(bus_if.gameState), mon_e.st);
      check({mon_e.tag, ".score"},   int'(bus_if.score),     mon_e.sc);
      check({mon_e.tag, ".hiscore"}, int'(bus_if.hiscore),   mon_e.hi);
      check({mon_e.tag, ".collide"}, int'(bus_if.collide),   mon_e.col);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_in(2'b00, 200, '0);
    step(2);
    rst_n = 1'b1;
    expect_at("reset", 1, IDLE, 0, 0, 0);
    step(1);

    // Jump edge reaches the FSM two frames after the button rises.
    set_in(2'b10, 200, '0);
    expect_at("idle_hold", 1, IDLE, 0, 0, 0);
    step(1);
    set_in(2'b00, 200, '0);
    expect_at("start", 1, PLAYING, 0, 0, 0);
    step(1);

    // Pipe steps 61 -> 60 -> 60 -> 59: one point only.
    set_in(2'b00, 180, pipe(61, 150));
    expect_at("pre_line", 1, PLAYING, 0, 0, 0);
    step(1);
    set_in(2'b00, 180, pipe(60, 150));
    expect_at("pass", 1, PLAYING, 1, 0, 0);
    step(1);
    expect_at("pass_hold", 1, PLAYING, 1, 0, 0);
    step(1);
    set_in(2'b00, 180, pipe(59, 150));
    expect_at("pass_after", 1, PLAYING, 1, 0, 0);
    step(1);

    // Geometry boundaries that must not collide.
    set_in(2'b00, 464, '0);
    expect_at("floor_edge", 1, PLAYING, 1, 0, 0);
    step(1);
    set_in(2'b00, 0, '0);
    expect_at("ceiling_edge", 1, PLAYING, 1, 0, 0);
    step(1);
    set_in(2'b00, 100, pipe(116, 150));
    expect_at("pipe_right_edge", 1, PLAYING, 1, 0, 0);
    step(1);
    set_in(2'b00, 214, pipe(110, 150));
    expect_at("gap_bottom_edge", 1, PLAYING, 1, 0, 0);
    step(1);

    // Pipe hit: collide next frame, DYING the frame after, OVER after 60 DYING frames.
    set_in(2'b00, 100, pipe(110, 150));
    expect_at("hit", 1, PLAYING, 1, 0, 1);
    expect_at("hit_dying", 2, DYING, 1, 0, 1);
    step(2);
    set_in(2'b00, 200, '0);
    expect_at("dying_clear", 1, DYING, 1, 0, 0);
    expect_at("dying_last", 59, DYING, 1, 0, 0);
    expect_at("over", 60, OVER, 1, hi(1), 0);
    step(60);

    // Jump alone is ignored in OVER.
    set_in(2'b10, 200, '0);
    step(1);
    set_in(2'b00, 200, '0);
    expect_at("over_jump", 2, OVER, 1, hi(1), 0);
    step(2);

    // Jump + restart in OVER -> IDLE.
    set_in(2'b11, 200, '0);
    expect_at("both_over_wait", 1, OVER, 1, hi(1), 0);
    step(1);
    set_in(2'b00, 200, '0);
    expect_at("both_over", 1, IDLE, 1, hi(1), 0);
    step(1);

    // Jump + restart in IDLE -> PLAYING, score cleared.
    set_in(2'b11, 200, '0);
    expect_at("both_idle_wait", 1, IDLE, 1, hi(1), 0);
    step(1);
    set_in(2'b00, 200, '0);
    expect_at("both_idle", 1, PLAYING, 0, hi(1), 0);
    step(1);
    set_in(2'b00, 180, pipe(60, 150));
    expect_at("pass2", 1, PLAYING, 1, hi(1), 0);
    step(1);

    // Bird above the screen.
    set_in(2'b00, -5, '0);
    expect_at("neg_bird", 1, PLAYING, 1, hi(1), 1);
    expect_at("neg_dying", 2, DYING, 1, hi(1), 1);
    step(2);

    // Asynchronous reset mid-DYING clears everything before the next clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.state",   int'(bus_if.gameState), int'(IDLE));
    check("async_rst.score",   int'(bus_if.score),     0);
    check("async_rst.hiscore", int'(bus_if.hiscore),   0);
    check("async_rst.collide", int'(bus_if.collide),   0);
    set_in(2'b00, 200, '0);
    step(1);
    rst_n = 1'b1;
    step(1);

    set_in(2'b10, 200, '0);
    step(1);
    set_in(2'b00, 200, '0);
    expect_at("replay", 1, PLAYING, 0, 0, 0);
    step(1);

    // Pass and collision in the same frame: collision wins.
    set_in(2'b00, -5, pipe(60, 150));
    expect_at("pass_vs_hit", 1, PLAYING, 0, 0, 1);
    expect_at("pvh_dying", 2, DYING, 0, 0, 1);
    step(2);
    set_in(2'b00, 200, '0);
    expect_at("pvh_over", 60, OVER, 0, 0, 0);
    step(60);

    set_in(2'b01, 200, '0);
    step(1);
    set_in(2'b00, 200, '0);
    expect_at("to_idle", 1, IDLE, 0, 0, 0);
    step(1);
    set_in(2'b10, 180, '0);
    step(1);
    set_in(2'b00, 180, '0);
    expect_at("play3", 1, PLAYING, 0, 0, 0);
    step(1);

    // 1000 passes: BCD carries and saturation at 999.
    for (int i = 0; i < 1000; i++) begin
      set_in(2'b00, 180, pipe(60, 150));
      step(1);
      set_in(2'b00, 180, '0);
      if (i == 9)   expect_at("bcd_010", 1, PLAYING, 'h010, 0, 0);
      if (i == 99)  expect_at("bcd_100", 1, PLAYING, 'h100, 0, 0);
      if (i == 998) expect_at("bcd_999", 1, PLAYING, 'h999, 0, 0);
      if (i == 999) expect_at("saturate", 1, PLAYING, 'h999, 0, 0);
      step(1);
    end

    // Bird below the floor; hiscore takes the saturated score.
    set_in(2'b00, 470, '0);
    expect_at("floor", 1, PLAYING, 'h999, 0, 1);
    expect_at("floor_dying", 2, DYING, 'h999, 0, 1);
    step(2);
    set_in(2'b00, 200, '0);
    expect_at("final_over", 60, OVER, 'h999, hi('h999), 0);
    step(62);

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
